// File: rtl/key_led_mode_ctrl.sv
// key_led_mode_ctrl: per-channel key -> LED mode controller (OFF -> SLOW -> FAST -> ON -> OFF).
// Latency: mode/LED update 3 edges after key_in is first sampled low, plus DEB_MAX+1 with debounce.
// Backpressure: none; every qualified press is honoured, and all channels run independently.
// Ports: sys_clk; sys_rst_n (async, active low); key_in[CH] (raw keys, active low);
//        led_out[CH] (active low); led_mode[2*CH] (channel i at bits [2i+1:2i]).
// Option: define KEY_DEBOUNCE_EN to insert the DEB_MAX debounce stage after the synchroniser.
module key_led_mode_ctrl #(
  parameter int               CH       = 4,
  parameter int               CNT_W    = 25,
  parameter logic [CNT_W-1:0] SLOW_MAX = 25'd24_999_999,
  parameter logic [CNT_W-1:0] FAST_MAX = 25'd6_249_999,
  parameter logic [19:0]      DEB_MAX  = 20'd999_999
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic [CH-1:0]   key_in,
  output logic [CH-1:0]   led_out,
  output logic [2*CH-1:0] led_mode
);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_SLOW = 2'b01,
    MODE_FAST = 2'b10,
    MODE_ON   = 2'b11
  } mode_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Counts the first two edges after reset; until then sync stage 2 still
  // holds its reset value rather than the real key level.
  logic [1:0] settle_cnt;
  logic       settled;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      settle_cnt <= 2'd0;
    end else if (settle_cnt != 2'd2) begin
      settle_cnt <= settle_cnt + 2'd1;
    end
  end

  assign settled = (settle_cnt == 2'd2);

`ifndef KEY_DEBOUNCE_EN
  // DEB_MAX only shapes the debounce stage, which is absent in this build.
  if (DEB_MAX == 20'd0) begin : g_deb_max_unused
  end
`endif

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic             sync1;
    logic             sync2;
    logic             lvl;
    logic             lvl_d;
    logic             press;
    logic             armed;
    mode_t            mode;
    logic [CNT_W-1:0] cnt;
    logic             led;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
      end else begin
        sync1 <= key_in[i];
        sync2 <= sync1;
      end
    end

`ifdef KEY_DEBOUNCE_EN
    logic        deb;
    logic [19:0] deb_cnt;

    // The debounced level only follows sync2 after it has differed for
    // DEB_MAX+1 consecutive cycles; any return to the old level restarts the count.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        deb     <= 1'b1;
        deb_cnt <= 20'd0;
      end else if (sync2 == deb) begin
        deb_cnt <= 20'd0;
      end else if (deb_cnt == DEB_MAX) begin
        deb     <= sync2;
        deb_cnt <= 20'd0;
      end else begin
        deb_cnt <= deb_cnt + 20'd1;
      end
    end

    assign lvl = deb;
`else
    assign lvl = sync2;
`endif

    // A channel only arms once its key has been seen released after reset,
    // so a key held through reset release does not count as a press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        lvl_d <= 1'b1;
        press <= 1'b0;
        armed <= 1'b0;
      end else begin
        lvl_d <= lvl;
        press <= armed & lvl_d & ~lvl;
        if (settled & sync2 & lvl) begin
          armed <= 1'b1;
        end
      end
    end

    // Mode FSM with the blink counter and LED register. Entering SLOW/FAST
    // lights the LED on the same edge so the first lit phase is full length.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        mode <= MODE_OFF;
        cnt  <= '0;
        led  <= 1'b1;
      end else if (press) begin
        cnt <= '0;
        case (mode)
          MODE_OFF:  begin mode <= MODE_SLOW; led <= 1'b0; end
          MODE_SLOW: begin mode <= MODE_FAST; led <= 1'b0; end
          MODE_FAST: begin mode <= MODE_ON;   led <= 1'b0; end
          default:   begin mode <= MODE_OFF;  led <= 1'b1; end
        endcase
      end else begin
        case (mode)
          MODE_SLOW: begin
            if (cnt == SLOW_MAX) begin
              cnt <= '0;
              led <= ~led;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          MODE_FAST: begin
            if (cnt == FAST_MAX) begin
              cnt <= '0;
              led <= ~led;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          MODE_ON: begin
            cnt <= '0;
            led <= 1'b0;
          end
          default: begin
            cnt <= '0;
            led <= 1'b1;
          end
        endcase
      end
    end

    assign led_out[i]         = led;
    assign led_mode[2*i +: 2] = mode;
  end

endmodule

// File: tb/tb_key_led_mode_ctrl.sv
// tb_key_led_mode_ctrl: directed bench for key_led_mode_ctrl with a behavioural reference.
// Latency: reference predicts outputs after every edge; compared on each falling edge.
// Backpressure: not applicable; stimulus drives keys and reset only.
module tb_key_led_mode_ctrl;
  localparam int CH       = 2;
  localparam int CNT_W    = 25;
  localparam int SLOW_MAX = 9;
  localparam int FAST_MAX = 3;
  localparam int DEB_MAX  = 4;
`ifdef KEY_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif
  // Edges from the first low key sample to the mode change.
  localparam int LAT  = DEB_EN ? DEB_MAX + 4 : 3;
  // Edges from the sample where the settled key level falls to the mode change.
  localparam int PIPE = DEB_EN ? 4 : 3;

  logic            sys_clk   = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic [CH-1:0]   key_in    = '0;
  logic [CH-1:0]   led_out;
  logic [2*CH-1:0] led_mode;

  key_led_mode_ctrl #(
    .CH       (CH),
    .CNT_W    (CNT_W),
    .SLOW_MAX (25'(SLOW_MAX)),
    .FAST_MAX (25'(FAST_MAX)),
    .DEB_MAX  (20'(DEB_MAX))
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_in),
    .led_out   (led_out),
    .led_mode  (led_mode)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference state: settled key level per channel, run length of equal raw
  // samples, pending mode changes by edge index, and mode entry time.
  int              cyc = 0;
  bit              prev_s  [CH];
  int              run     [CH];
  bit              lvl_m   [CH];
  bit              armed_m [CH];
  bit              pend    [CH][8];
  int              mode_m  [CH];
  int              t0      [CH];
  logic [CH-1:0]   exp_led  = '1;
  logic [2*CH-1:0] exp_mode = '0;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  initial begin
    int  n;
    bit  s;
    bit  old_l;
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        for (int c = 0; c < CH; c++) begin
          prev_s[c]  = 1'b1;
          run[c]     = 0;
          lvl_m[c]   = 1'b1;
          armed_m[c] = 1'b0;
          mode_m[c]  = 0;
          t0[c]      = 0;
          for (int k = 0; k < 8; k++) pend[c][k] = 1'b0;
        end
        exp_led  = '1;
        exp_mode = '0;
      end else begin
        n = cyc;
        for (int c = 0; c < CH; c++) begin
          s      = key_in[c];
          run[c] = (s == prev_s[c]) ? run[c] + 1 : 1;
          prev_s[c] = s;
          old_l  = lvl_m[c];
          if (!DEB_EN) lvl_m[c] = s;
          else if (s != lvl_m[c] && run[c] >= DEB_MAX + 1) lvl_m[c] = s;
          if (old_l && !lvl_m[c] && armed_m[c]) pend[c][(n + PIPE) % 8] = 1'b1;
          if (s && lvl_m[c]) armed_m[c] = 1'b1;
          if (pend[c][n % 8]) begin
            pend[c][n % 8] = 1'b0;
            mode_m[c] = (mode_m[c] + 1) % 4;
            t0[c] = n;
          end
          case (mode_m[c])
            0:       exp_led[c] = 1'b1;
            1:       exp_led[c] = (((n - t0[c]) / (SLOW_MAX + 1)) % 2) == 1;
            2:       exp_led[c] = (((n - t0[c]) / (FAST_MAX + 1)) % 2) == 1;
            default: exp_led[c] = 1'b0;
          endcase
          exp_mode[2*c +: 2] = 2'(mode_m[c]);
        end
        cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      if (chk_en) begin
        check("model_led_out",  8'(led_out),  8'(exp_led));
        check("model_led_mode", 8'(led_mode), 8'(exp_mode));
      end
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge sys_clk);
  endtask

  task automatic press(input logic [CH-1:0] m, input int low, input int gap);
    key_in = key_in & ~m;
    cycles(low);
    key_in = key_in | m;
    cycles(gap);
  endtask

  initial begin
    // Reset with both keys held down, released while still held.
    key_in    = '0;
    sys_rst_n = 1'b0;
    cycles(3);
    check("rst_led_out",  8'(led_out),  8'h03);
    check("rst_led_mode", 8'(led_mode), 8'h00);
    sys_rst_n = 1'b1;
    cycles(1);
    chk_en = 1'b1;
    cycles(30);
    check("held_led_out",  8'(led_out),  8'h03);
    check("held_led_mode", 8'(led_mode), 8'h00);
    key_in = '1;
    cycles(20);

    // Clean press on ch0: exact latency, then first slow toggle.
    key_in[0] = 1'b0;
    cycles(LAT);
    check("press_before_mode", 8'(led_mode), 8'h00);
    cycles(1);
    check("press_mode_slow", 8'(led_mode), 8'h01);
    check("press_led_lit",   8'(led_out),  8'h02);
    cycles(SLOW_MAX + 1);
    check("slow_toggle_led",  8'(led_out),  8'h03);
    check("slow_toggle_mode", 8'(led_mode), 8'h01);
    key_in[0] = 1'b1;
    cycles(25);

    // Remaining steps of the cycle on ch0.
    press(2'b01, 10, 25);
    check("step_fast_mode", 8'(led_mode), 8'h02);
    press(2'b01, 10, 25);
    check("step_on_mode", 8'(led_mode), 8'h03);
    check("step_on_led",  8'(led_out),  8'h02);
    press(2'b01, 10, 25);
    check("step_off_mode", 8'(led_mode), 8'h00);
    check("step_off_led",  8'(led_out),  8'h03);

    // Bouncing ch0: three short glitches, then a stable press.
    for (int g = 0; g < 3; g++) begin
      key_in[0] = 1'b0;
      cycles(3);
      key_in[0] = 1'b1;
      cycles(3);
    end
    press(2'b01, 10, 25);
    check("bounce_mode", 8'(led_mode), DEB_EN ? 8'h01 : 8'h00);
    if (!DEB_EN) press(2'b01, 10, 25);

    // Simultaneous press, timed so ch0's counter is 7 on the changing edge.
    for (int g = 0; g < 20 && ((cyc + LAT - 1 - t0[0]) % (SLOW_MAX + 1)) != 7; g++) cycles(1);
    key_in = '0;
    cycles(LAT);
    check("simul_before_mode", 8'(led_mode), 8'h01);
    cycles(1);
    check("simul_mode", 8'(led_mode), 8'h06);
    check("simul_led",  8'(led_out),  8'h00);
    cycles(FAST_MAX + 1);
    check("simul_fast_toggle", 8'(led_out), 8'h01);
    key_in = '1;
    cycles(25);

    // Asynchronous reset in the middle of a blink phase.
    cycles(5);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_led",  8'(led_out),  8'h03);
    check("async_rst_mode", 8'(led_mode), 8'h00);
    cycles(3);
    sys_rst_n = 1'b1;
    cycles(10);
    press(2'b10, 10, 25);
    check("after_rst_mode", 8'(led_mode), 8'h04);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
